// File: rtl/barrel_sched.sv
// Round-robin scheduler for two requesters sharing one 32-bit logical barrel shifter.
// Optional per-requester grant counters are enabled by defining BARREL_SCHED_STATS_EN.
module barrel_sched #(
  parameter int PRIO_INIT = 0,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_data,
  input  logic             req0_dir,
  input  logic [4:0]       req0_sh,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_data,
  input  logic             req1_dir,
  input  logic [4:0]       req1_sh,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [31:0]      rsp_data,
  output logic [1:0]       dbg_state_o
`ifdef BARREL_SCHED_STATS_EN
  ,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
`endif
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // req*_ready depends only on state, prio and req*_valid; rsp*_valid is registered.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t      state_q;
  logic        prio_q;
  logic        gid_q;
  logic [31:0] op_data_q;
  logic        op_dir_q;
  logic [4:0]  op_sh_q;
  logic [31:0] rsp_data_q;
  logic        rsp0_valid_q;
  logic        rsp1_valid_q;

  logic [31:0] shift_d;
  logic        gnt0;
  logic        gnt1;
  logic        rsp_hs;

  if ((PRIO_INIT != 0 && PRIO_INIT != 1) || CNT_W < 1) begin : g_param_check
    $error("barrel_sched: PRIO_INIT must be 0 or 1 and CNT_W at least 1");
  end

  always_comb begin
    shift_d = op_dir_q ? (op_data_q >> op_sh_q) : (op_data_q << op_sh_q);
    // Priority only matters when both requesters are valid.
    gnt0    = (state_q == S_IDLE) && req0_valid && (!req1_valid || !prio_q);
    gnt1    = (state_q == S_IDLE) && req1_valid && (!req0_valid || prio_q);
    rsp_hs  = (state_q == S_RESP) && (gid_q ? rsp1_ready : rsp0_ready);
  end

  assign req0_ready  = gnt0;
  assign req1_ready  = gnt1;
  assign rsp0_valid  = rsp0_valid_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp_data    = rsp_data_q;
  assign dbg_state_o = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      prio_q       <= (PRIO_INIT != 0);
      gid_q        <= 1'b0;
      op_data_q    <= 32'd0;
      op_dir_q     <= 1'b0;
      op_sh_q      <= 5'd0;
      rsp_data_q   <= 32'd0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gnt0 || gnt1) begin
            gid_q     <= gnt1;
            op_data_q <= gnt1 ? req1_data : req0_data;
            op_dir_q  <= gnt1 ? req1_dir  : req0_dir;
            op_sh_q   <= gnt1 ? req1_sh   : req0_sh;
            state_q   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          rsp_data_q   <= shift_d;
          rsp0_valid_q <= !gid_q;
          rsp1_valid_q <= gid_q;
          state_q      <= S_RESP;
        end
        S_RESP: begin
          // Priority moves only here, so a waiting requester always gets the next grant.
          if (rsp_hs) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            prio_q       <= !gid_q;
            state_q      <= S_IDLE;
          end
        end
        default: begin
          rsp0_valid_q <= 1'b0;
          rsp1_valid_q <= 1'b0;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

`ifdef BARREL_SCHED_STATS_EN
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (gnt0) cnt0_q <= cnt0_q + CNT_W'(1);
      if (gnt1) cnt1_q <= cnt1_q + CNT_W'(1);
    end
  end

  assign gnt_cnt0 = cnt0_q;
  assign gnt_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_barrel_sched.sv
// Directed bench for barrel_sched: reset, shift vectors, contention, backpressure, mid-op reset.
// Define BARREL_SCHED_STATS_EN to also check the grant counters (built with CNT_W=4).
module tb_barrel_sched;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_data, req1_data;
  logic        req0_dir, req1_dir;
  logic [4:0]  req0_sh, req1_sh;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [31:0] rsp_data;
  logic [1:0]  dbg_state;
`ifdef BARREL_SCHED_STATS_EN
  logic [3:0]  gnt_cnt0, gnt_cnt1;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  barrel_sched #(
    .PRIO_INIT(0)
`ifdef BARREL_SCHED_STATS_EN
    , .CNT_W(4)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req0_dir(req0_dir), .req0_sh(req0_sh),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .req1_dir(req1_dir), .req1_sh(req1_sh),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .dbg_state_o(dbg_state)
`ifdef BARREL_SCHED_STATS_EN
    , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`endif
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int id, input logic v, input logic [31:0] d,
                         input logic dir, input logic [4:0] sh);
    if (id == 0) begin
      req0_valid = v; req0_data = d; req0_dir = dir; req0_sh = sh;
    end else begin
      req1_valid = v; req1_data = d; req1_dir = dir; req1_sh = sh;
    end
  endtask

  // One complete operation from a single requester with the response taken at once.
  task automatic do_op(input int id, input logic [31:0] d, input logic dir,
                       input logic [4:0] sh, input logic [31:0] exp);
    @(negedge clk);
    set_req(id, 1'b1, d, dir, sh);
    set_req(1 - id, 1'b0, 32'd0, 1'b0, 5'd0);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    chk("op_req0_ready", 32'(req0_ready), 32'(id == 0));
    chk("op_req1_ready", 32'(req1_ready), 32'(id == 1));
    @(negedge clk);
    set_req(id, 1'b0, d, dir, sh);
    #1;
    chk("op_shift_rsp_valids", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    @(negedge clk); #1;
    chk("op_rsp0_valid", 32'(rsp0_valid), 32'(id == 0));
    chk("op_rsp1_valid", 32'(rsp1_valid), 32'(id == 1));
    chk("op_rsp_data", rsp_data, exp);
    @(negedge clk); #1;
    chk("op_rsp_done", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    set_req(0, 1'b0, 32'd0, 1'b0, 5'd0);
    set_req(1, 1'b0, 32'd0, 1'b0, 5'd0);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // Reset state
    @(negedge clk); #1;
    chk("rst_req_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    chk("rst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request and shift vectors; prio after: 1,0,0,1,0
    do_op(0, 32'h8000_0001, 1'b1, 5'd1,  32'h4000_0000);
    do_op(1, 32'hFFFF_FFFF, 1'b0, 5'd31, 32'h8000_0000);
    do_op(1, 32'hFFFF_FFFF, 1'b0, 5'd0,  32'hFFFF_FFFF);
    do_op(0, 32'hDEAD_BEEF, 1'b1, 5'd8,  32'h00DE_ADBE);
    do_op(1, 32'h1234_5678, 1'b0, 5'd4,  32'h2345_6780);

    // Contention: grants must alternate 0,1,0,1
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        set_req(0, 1'b1, 32'h0000_00F0, 1'b1, 5'd4);
        set_req(1, 1'b1, 32'h0000_0001, 1'b0, 5'd16);
      end
      #1;
      chk("cont_req0_ready", 32'(req0_ready), 32'(k % 2 == 0));
      chk("cont_req1_ready", 32'(req1_ready), 32'(k % 2 == 1));
      exp_q.push_back((k % 2 == 0) ? 32'h0000_000F : 32'h0001_0000);
      @(negedge clk); #1;
      chk("cont_shift_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      @(negedge clk); #1;
      chk("cont_rsp0_valid", 32'(rsp0_valid), 32'(k % 2 == 0));
      chk("cont_rsp1_valid", 32'(rsp1_valid), 32'(k % 2 == 1));
      chk("cont_rsp_data", rsp_data, exp_q.pop_front());
    end
    @(negedge clk);
    set_req(0, 1'b0, 32'd0, 1'b0, 5'd0);
    set_req(1, 1'b0, 32'd0, 1'b0, 5'd0);

    // Response backpressure on req0 with req1 waiting; prio is 0 here
    @(negedge clk);
    set_req(0, 1'b1, 32'h0000_FFFF, 1'b0, 5'd8);
    set_req(1, 1'b1, 32'h8000_0000, 1'b1, 5'd31);
    rsp0_ready = 1'b0; rsp1_ready = 1'b1;
    #1;
    chk("bp_req0_ready", 32'(req0_ready), 32'd1);
    chk("bp_req1_ready", 32'(req1_ready), 32'd0);
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    chk("bp_shift_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("bp_hold_rsp0_valid", 32'(rsp0_valid), 32'd1);
      chk("bp_hold_rsp_data", rsp_data, 32'h00FF_FF00);
      chk("bp_hold_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      chk("bp_hold_rsp1_valid", 32'(rsp1_valid), 32'd0);
    end
    @(negedge clk);
    rsp0_ready = 1'b1;
    #1;
    chk("bp_release_rsp0_valid", 32'(rsp0_valid), 32'd1);
    @(negedge clk); #1;
    chk("bp_after_rsp0_valid", 32'(rsp0_valid), 32'd0);
    chk("bp_after_req1_ready", 32'(req1_ready), 32'd1);
    @(negedge clk);
    req1_valid = 1'b0;
    #1;
    @(negedge clk); #1;
    chk("bp_req1_rsp1_valid", 32'(rsp1_valid), 32'd1);
    chk("bp_req1_rsp0_valid", 32'(rsp0_valid), 32'd0);
    chk("bp_req1_rsp_data", rsp_data, 32'h0000_0001);
    @(negedge clk); #1;

    // Reset mid-operation; prio is 1 before the reset
    do_op(0, 32'h0000_0003, 1'b0, 5'd30, 32'hC000_0000);
    @(negedge clk);
    set_req(1, 1'b1, 32'hA5A5_A5A5, 1'b1, 5'd4);
    #1;
    chk("mr_req1_ready", 32'(req1_ready), 32'd1);
    @(negedge clk);
    req1_valid = 1'b0;
    #1;
    chk("mr_in_shift", 32'(dbg_state), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_rst_rsp_data", rsp_data, 32'd0);
    chk("mr_rst_valid_ready", {28'd0, rsp1_valid, rsp0_valid, req1_ready, req0_ready}, 32'd0);
    chk("mr_rst_state", 32'(dbg_state), 32'd0);
`ifdef BARREL_SCHED_STATS_EN
    chk("mr_rst_cnt", {24'd0, gnt_cnt1, gnt_cnt0}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("mr_no_stale_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    end
    @(negedge clk);
    set_req(0, 1'b1, 32'h0000_0001, 1'b0, 5'd31);
    set_req(1, 1'b1, 32'h0000_0002, 1'b0, 5'd1);
    #1;
    chk("mr_prio_init_req0", 32'(req0_ready), 32'd1);
    chk("mr_prio_init_req1", 32'(req1_ready), 32'd0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    @(negedge clk); #1;
    chk("mr_op_rsp0_valid", 32'(rsp0_valid), 32'd1);
    chk("mr_op_rsp_data", rsp_data, 32'h8000_0000);
    @(negedge clk); #1;

`ifdef BARREL_SCHED_STATS_EN
    // One req0 grant so far; 16 more wrap the 4-bit counter to 1
    for (int i = 0; i < 16; i++) begin
      do_op(0, 32'h0000_0010, 1'b1, 5'd4, 32'h0000_0001);
      if (i == 13) chk("cnt0_before_wrap", 32'(gnt_cnt0), 32'd15);
    end
    for (int i = 0; i < 3; i++) do_op(1, 32'h0000_0001, 1'b0, 5'd2, 32'h0000_0004);
    chk("cnt0_wrap", 32'(gnt_cnt0), 32'd1);
    chk("cnt1_track", 32'(gnt_cnt1), 32'd3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
